// File: rtl/wave_pkt_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_pkt_tx_if : control, sample FIFO and UDP-core signals            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface wave_pkt_tx_if;
    logic        enable;
    logic [15:0] freq_in;
    logic [12:0] fifo_rd_count;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic        err;
    logic [15:0] pkt_cnt;

    modport master (
        input  enable, freq_in, fifo_rd_count, fifo_rd_data, tx_req, tx_done,
        output fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, err, pkt_cnt
    );

    modport slave (
        output enable, freq_in, fifo_rd_count, fifo_rd_data, tx_req, tx_done,
        input  fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, err, pkt_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wave_pkt_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_pkt_tx : frames FIFO wave samples behind a 16-bit frequency      |
// | header and feeds them to a UDP transmit core. Rev 1.0                 |
// +----------------------------------------------------------------------+
module wave_pkt_tx #(
    parameter int PAYLOAD_SAMPLES = 1024,
    parameter int GAP_CYCLES      = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    wave_pkt_tx_if.master   bus
);

    localparam logic [12:0] SAMPLES_C = 13'(PAYLOAD_SAMPLES);
    localparam logic [12:0] BYTES_C   = 13'(PAYLOAD_SAMPLES + 2);
    localparam int          GAP_W     = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        START     = 3'd2,
        SEND      = 3'd3,
        WAIT_DONE = 3'd4,
        GAP       = 3'd5
    } state_t;

    state_t           state;
    logic [12:0]      byte_cnt;
    logic [15:0]      freq_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             data_sel;
    logic [7:0]       data_reg;
    logic             start_r;
    logic             err_r;
    logic [15:0]      pkt_cnt_r;
    logic             take_req;
    logic             rd_fire;

    // A request is only honoured while bytes remain and the frame is not being closed.
    assign take_req = (state == SEND) && bus.tx_req && !bus.tx_done && (byte_cnt < BYTES_C);
    assign rd_fire  = take_req && (byte_cnt >= 13'd2);

    assign bus.fifo_rd_en  = rd_fire;
    // FIFO data is passed straight through the cycle after a read, then held in data_reg.
    assign bus.tx_data     = data_sel ? bus.fifo_rd_data : data_reg;
    assign bus.tx_start_en = start_r;
    assign bus.tx_byte_num = 16'(PAYLOAD_SAMPLES + 2);
    assign bus.busy        = (state != IDLE);
    assign bus.err         = err_r;
    assign bus.pkt_cnt     = pkt_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            freq_lat  <= '0;
            gap_cnt   <= '0;
            data_sel  <= 1'b0;
            data_reg  <= '0;
            start_r   <= 1'b0;
            err_r     <= 1'b0;
            pkt_cnt_r <= '0;
        end else begin
            start_r  <= 1'b0;
            data_sel <= rd_fire;
            if (data_sel) begin
                data_reg <= bus.fifo_rd_data;
            end

            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (bus.fifo_rd_count >= SAMPLES_C) begin
                        state   <= START;
                        start_r <= 1'b1;
                    end
                end

                START: begin
                    freq_lat <= bus.freq_in;
                    byte_cnt <= '0;
                    state    <= SEND;
                end

                SEND: begin
                    if (bus.tx_done) begin
                        err_r   <= 1'b1;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (take_req) begin
                        byte_cnt <= byte_cnt + 13'd1;
                        if (byte_cnt == 13'd0) begin
                            data_reg <= freq_lat[15:8];
                        end else if (byte_cnt == 13'd1) begin
                            data_reg <= freq_lat[7:0];
                        end
                        if (byte_cnt == BYTES_C - 13'd1) begin
                            state <= WAIT_DONE;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        pkt_cnt_r <= pkt_cnt_r + 16'd1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= bus.enable ? WAIT_DATA : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/wave_pkt_tx.md
WAVE_PKT_TX -- requirements
Module: wave_pkt_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_SAMPLES, default 1024, meaning wave bytes per packet after the 2-byte frequency header (range 1..4093).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning idle clk cycles between a tx_done and the next packet start.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset rst_n is asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, level; when high, packets are sent back to back.
REQ-006 SHALL have port freq_in, input, 16, wave frequency word placed in the header.
REQ-007 SHALL have port fifo_rd_count, input, 13, occupancy of the sample FIFO.
REQ-008 SHALL have port fifo_rd_en, output, 1, sample FIFO read strobe.
REQ-009 SHALL have port fifo_rd_data, input, 8, FIFO output; valid the cycle after fifo_rd_en (standard, non-FWFT).
REQ-010 SHALL have port tx_start_en, output, 1, one-cycle pulse that starts a UDP transmission.
REQ-011 SHALL have port tx_byte_num, output, 16, payload length; constant PAYLOAD_SAMPLES+2.
REQ-012 SHALL have port tx_req, input, 1, UDP core byte request.
REQ-013 SHALL have port tx_data, output, 8, payload byte; valid the cycle after tx_req.
REQ-014 SHALL have port tx_done, input, 1, one-cycle pulse marking the end of the UDP frame.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port err, output, 1, sticky error flag.
REQ-017 SHALL have port pkt_cnt, output, 16, count of completed packets; wraps from 0xFFFF to 0.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_DATA, START, SEND, WAIT_DONE and GAP.
REQ-019 SHALL move from IDLE to WAIT_DATA when enable=1.
REQ-020 SHALL stay in WAIT_DATA until fifo_rd_count >= PAYLOAD_SAMPLES, then go to START.
REQ-021 SHALL in WAIT_DATA return to IDLE if enable=0.
REQ-022 SHALL in START assert tx_start_en for exactly one cycle, latch freq_in into freq_lat, clear byte_cnt, and go to SEND.
REQ-023 SHALL in SEND increment byte_cnt on each tx_req while byte_cnt < PAYLOAD_SAMPLES+2.
REQ-024 SHALL send the payload bytes in this order:
  - byte 0 = freq_lat[15:8];
  - byte 1 = freq_lat[7:0] (big-endian);
  - bytes 2.. = FIFO samples in FIFO order.
REQ-025 SHALL drive the header bytes onto tx_data from a register updated on the tx_req cycle.
REQ-026 SHALL set fifo_rd_en = tx_req combinationally for bytes 2..N+1, and tx_data = fifo_rd_data on the following cycle.
REQ-027 SHALL ignore tx_req when byte_cnt = PAYLOAD_SAMPLES+2, with no fifo_rd_en and tx_data holding its last value.
REQ-028 SHALL go from SEND to WAIT_DONE when byte_cnt reaches PAYLOAD_SAMPLES+2.
REQ-029 SHALL in WAIT_DONE, on tx_done, increment pkt_cnt and go to GAP.
REQ-030 SHALL in SEND, on tx_done before all bytes are sent, set err=1, not increment pkt_cnt, and go to GAP.
REQ-031 SHALL in GAP count GAP_CYCLES cycles, then go to WAIT_DATA if enable=1, else IDLE.
REQ-032 SHALL ignore enable deassertion during START, SEND or WAIT_DONE; the current packet completes.
REQ-033 SHALL ignore freq_in changes after START until the next START.
REQ-034 SHALL never assert fifo_rd_en outside SEND and never for header bytes; in total exactly PAYLOAD_SAMPLES reads per packet.
REQ-035 SHALL treat a tx_req arriving in the same cycle as tx_done during SEND per REQ-030, with no FIFO read.
REQ-036 SHALL ignore tx_done in IDLE, WAIT_DATA and GAP.

Reset
REQ-037 SHALL on rst_n=0 drive to 0: state (IDLE), tx_start_en, fifo_rd_en, tx_data, byte_cnt, freq_lat, gap counter, err, pkt_cnt.
REQ-038 SHALL make tx_byte_num constant PAYLOAD_SAMPLES+2 regardless of reset.
REQ-039 SHALL abandon a mid-packet transfer on reset, with no further tx_start_en until WAIT_DATA is satisfied again.
REQ-040 SHALL clear err only by reset.

Verification
REQ-041 SHALL cover basic packet: PAYLOAD_SAMPLES=4, freq_in=0x1388, FIFO holding 0x11,0x22,0x33,0x44, enable=1, tx_req every cycle -> one tx_start_en; tx_data sequence 0x13,0x88,0x11,0x22,0x33,0x44; 4 fifo_rd_en; pkt_cnt=1 after tx_done.
REQ-042 SHALL cover the data threshold: fifo_rd_count=3 with PAYLOAD_SAMPLES=4 -> no tx_start_en; raising it to 4 -> tx_start_en within 2 cycles.
REQ-043 SHALL cover a mid-packet freq change: freq_in changed to 0x0FA0 after START -> header still 0x13,0x88; next packet header 0x0F,0xA0.
REQ-044 SHALL cover early tx_done: tx_done after 3 bytes -> err=1, pkt_cnt unchanged, FSM returns through GAP.
REQ-045 SHALL cover enable drop and gap: enable=0 during SEND -> packet completes, then IDLE; with enable=1, two starts are separated by >= GAP_CYCLES after tx_done.
REQ-046 SHALL cover extra requests and reset: tx_req pulses after the last byte -> no fifo_rd_en; rst_n low mid-SEND -> all outputs 0, state IDLE.
